// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard for the ID-stage hazard unit.
// Each architectural register carries a count of cycles until its pending result
// can reach an ID-stage branch comparator. EX consumers need BR_EXTRA fewer cycles.
// The count is loaded with lat_d + BR_EXTRA when a writer issues, and otherwise
// decrements to zero.
// The stall decision is purely combinational from the current counts and the ID inputs.
// Optional feature: define HAZARD_STATS_EN to build a 32-bit hazard stall counter.
// Without it, stall_cycles is tied to zero.
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 3,
    parameter int BR_EXTRA = 1,
    localparam int CNT_W   = $clog2(MAX_LAT + BR_EXTRA + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_d,
    input  logic [ADDR_W-1:0] rt_d,
    input  logic              rs_used_d,
    input  logic              rt_used_d,
    input  logic              wr_d,
    input  logic [ADDR_W-1:0] dst_d,
    input  logic [CNT_W-1:0]  lat_d,
    input  logic              branch_d,
    input  logic              taken_d,
    input  logic              jump_d,
    input  logic              freeze,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              flush_d,
    output logic [31:0]       stall_cycles
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] MAX_LAT_C  = CNT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] BR_EXTRA_C = CNT_W'(BR_EXTRA);

    // cnt[0] is never loaded, so r0 never looks busy.
    logic [CNT_W-1:0] cnt [NUM_REGS];

    logic             rs_busy;
    logic             rt_busy;
    logic             hz;
    logic             issue;
    logic [CNT_W-1:0] lat_eff;
    logic [CNT_W-1:0] load_val;

    // Hazard detection and pipeline control from pre-issue scoreboard state.
    // Branches compare in ID, so they wait for a count of zero.
    // EX consumers can take the bypass once the count is down to BR_EXTRA.
    always_comb begin
        rs_busy  = (rs_d != '0) &&
                   (branch_d ? (cnt[rs_d] != '0) : (cnt[rs_d] > BR_EXTRA_C));
        rt_busy  = (rt_d != '0) &&
                   (branch_d ? (cnt[rt_d] != '0) : (cnt[rt_d] > BR_EXTRA_C));
        hz       = (rs_used_d && rs_busy) || (rt_used_d && rt_busy);
        issue    = !hz && !freeze;
        stall_f  = hz || freeze;
        stall_d  = hz || freeze;
        flush_e  = hz && !freeze;
        flush_d  = !hz && !freeze && (jump_d || (branch_d && taken_d));
        lat_eff  = (lat_d > MAX_LAT_C) ? MAX_LAT_C : lat_d;
        load_val = lat_eff + BR_EXTRA_C;
    end

    // Scoreboard counters. Freeze holds all counts.
    // An issuing writer reloads its destination, and that reload takes priority
    // over the decrement. All other nonzero counts decrement by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r == 0) begin
                    cnt[r] <= '0;
                end else if (issue && wr_d && (dst_d == ADDR_W'(r))) begin
                    cnt[r] <= load_val;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Flag illegal latency classes in simulation. The datapath clamps them to MAX_LAT.
    always @(posedge clk) begin
        if (rst_n && issue && wr_d) begin
            assert (lat_d <= MAX_LAT_C)
            else $error("hazard_scoreboard: lat_d %0d exceeds MAX_LAT %0d", lat_d, MAX_LAT);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;

    // Count every active cycle lost to a data hazard. The counter wraps naturally at 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hz && !freeze) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bench for hazard_scoreboard (ADDR_W=5, MAX_LAT=3, BR_EXTRA=1).
// Inputs change just after the falling edge. Outputs are sampled 1 ns later,
// well away from the rising edge that updates the scoreboard.
// The control outputs are packed as {stall_f, stall_d, flush_e, flush_d}.
module tb_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rs_d;
    logic [ADDR_W-1:0] rt_d;
    logic              rs_used_d;
    logic              rt_used_d;
    logic              wr_d;
    logic [ADDR_W-1:0] dst_d;
    logic [CNT_W-1:0]  lat_d;
    logic              branch_d;
    logic              taken_d;
    logic              jump_d;
    logic              freeze;
    logic              stall_f;
    logic              stall_d;
    logic              flush_e;
    logic              flush_d;
    logic [31:0]       stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.ADDR_W(5), .MAX_LAT(3), .BR_EXTRA(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_used_d    (rs_used_d),
        .rt_used_d    (rt_used_d),
        .wr_d         (wr_d),
        .dst_d        (dst_d),
        .lat_d        (lat_d),
        .branch_d     (branch_d),
        .taken_d      (taken_d),
        .jump_d       (jump_d),
        .freeze       (freeze),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .flush_d      (flush_d),
        .stall_cycles (stall_cycles)
    );

    // Clock generation: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return all ID inputs to a no-op instruction.
    task automatic idle();
        rs_d = '0; rt_d = '0; rs_used_d = 1'b0; rt_used_d = 1'b0;
        wr_d = 1'b0; dst_d = '0; lat_d = '0;
        branch_d = 1'b0; taken_d = 1'b0; jump_d = 1'b0; freeze = 1'b0;
    endtask

    // Present a writer instruction with no source operands.
    task automatic drive_wr(input logic [ADDR_W-1:0] dst, input logic [CNT_W-1:0] lat);
        idle();
        wr_d = 1'b1; dst_d = dst; lat_d = lat;
    endtask

    // Present a reader of rs, either as a branch or as an EX consumer.
    task automatic drive_rd(input logic [ADDR_W-1:0] src, input logic br, input logic tk);
        idle();
        rs_d = src; rs_used_d = 1'b1; branch_d = br; taken_d = tk;
    endtask

    // Advance one full cycle: rising edge, then back to the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare the packed control outputs against the expected value.
    task automatic chk_o(input string tag, input logic [3:0] exp_v);
        logic [3:0] obs;
        #1;
        obs = {stall_f, stall_d, flush_e, flush_d};
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Compare the stall counter against the expected value.
    task automatic chk_s(input string tag, input int n);
        logic [31:0] exp_v;
`ifdef HAZARD_STATS_EN
        exp_v = 32'(n);
`else
        exp_v = 32'h0;
        if (n < 0) exp_v = 32'h1;
`endif
        checks++;
        assert (stall_cycles === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, stall_cycles, exp_v);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        chk_o("reset_outputs", 4'b0000);
        chk_s("reset_stats", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: build cnt[5]=3, stall a reader, then reset mid-cycle.
        drive_wr(5'd5, 3'd2);           chk_o("t1_issue", 4'b0000); step();
        drive_rd(5'd5, 1'b0, 1'b0);     chk_o("t1_busy", 4'b1110);
        #1 rst_n = 1'b0;
        chk_o("t1_in_reset", 4'b0000);
        chk_s("t1_stats_reset", 0);
        step();
        rst_n = 1'b1;
        idle();                         chk_o("t1_idle_after", 4'b0000);
        drive_rd(5'd5, 1'b0, 1'b0);     chk_o("t1_no_stall_after", 4'b0000); step();

        // 2: load-use. A load with lat 1 causes exactly one stall cycle for the dependent add.
        drive_wr(5'd8, 3'd1);           chk_o("t2_lw_issue", 4'b0000); step();
        drive_rd(5'd8, 1'b0, 1'b0); wr_d = 1'b1; dst_d = 5'd10; lat_d = 3'd0;
        chk_o("t2_add_stall", 4'b1110); step();
        chk_o("t2_add_issue", 4'b0000); step();

        // 3: mul latency 3. A branch stalls 4 cycles; an EX reader stalls 3 cycles.
        drive_wr(5'd9, 3'd3);           chk_o("t3_mul_issue", 4'b0000); step();
        drive_rd(5'd9, 1'b1, 1'b0); rt_used_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_o($sformatf("t3_br_stall%0d", i), 4'b1110); step();
        end
        chk_o("t3_br_issue", 4'b0000); step();
        drive_wr(5'd9, 3'd3);           chk_o("t3_mul2_issue", 4'b0000); step();
        drive_rd(5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_o($sformatf("t3_ex_stall%0d", i), 4'b1110); step();
        end
        chk_o("t3_ex_issue", 4'b0000); step();

        // 4: freeze in the middle of a countdown holds the count.
        drive_wr(5'd11, 3'd2);          chk_o("t4_issue", 4'b0000); step();
        drive_rd(5'd11, 1'b0, 1'b0);    chk_o("t4_stall_a", 4'b1110); step();
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_o($sformatf("t4_frozen%0d", i), 4'b1100); step();
        end
        freeze = 1'b0;
        chk_o("t4_stall_b", 4'b1110); step();
        chk_o("t4_release", 4'b0000); step();

        // 5: control flow. A jump flushes for one cycle; a taken branch waits on a busy source.
        idle(); jump_d = 1'b1;          chk_o("t5_jump", 4'b0001);
        freeze = 1'b1;                  chk_o("t5_jump_frozen", 4'b1100);
        freeze = 1'b0;                  step();
        idle();                         chk_o("t5_after_jump", 4'b0000);
        drive_wr(5'd12, 3'd0);          chk_o("t5_prod", 4'b0000); step();
        drive_rd(5'd12, 1'b1, 1'b1);    chk_o("t5_br_busy", 4'b1110); step();
        chk_o("t5_br_taken", 4'b0001); step();

        // 6: r0 is never tracked; re-issuing to a busy register reloads its count.
        drive_wr(5'd0, 3'd3);           chk_o("t6_r0_write", 4'b0000); step();
        drive_rd(5'd0, 1'b1, 1'b0); rt_used_d = 1'b1;
        chk_o("t6_r0_read", 4'b0000); step();
        drive_wr(5'd4, 3'd3);           chk_o("t6_long", 4'b0000); step();
        drive_wr(5'd4, 3'd0);           chk_o("t6_reload", 4'b0000); step();
        drive_rd(5'd4, 1'b1, 1'b0);     chk_o("t6_br_stall", 4'b1110); step();
        chk_o("t6_br_issue", 4'b0000); step();
        drive_wr(5'd4, 3'd3);           chk_o("t6_long2", 4'b0000); step();
        drive_wr(5'd4, 3'd0);           chk_o("t6_reload2", 4'b0000); step();
        idle(); rt_d = 5'd4; rt_used_d = 1'b1;
        chk_o("t6_ex_no_stall", 4'b0000); step();
        chk_s("t6_stats_total", 12);

        // Self-dependency: the writer is not stalled by its own pending write; the next reader is.
        drive_rd(5'd14, 1'b0, 1'b0); wr_d = 1'b1; dst_d = 5'd14; lat_d = 3'd3;
        chk_o("sd_no_self_stall", 4'b0000); step();
        drive_rd(5'd14, 1'b0, 1'b0);    chk_o("sd_reader_stall", 4'b1110);
        #1 rst_n = 1'b0;
        chk_o("sd_reset_clears", 4'b0000);
        chk_s("sd_stats_reset", 0);
        step();
        rst_n = 1'b1;
        chk_o("sd_after_reset", 4'b0000); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
